// File: rtl/conv3x3_row_engine_pkg.sv
// conv_pkg: shared definitions for the 3x3 row convolution engine.
//   mode_e      - output mode encodings (reserved code behaves as CLAMP)
//   state_e     - sequencer FSM states
//   acc_width() - signed accumulator width for nine PIX_W x PIX_W products
//   K_*         - kernel weight indices, row-major, w0 = top-left
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_CLAMP  = 2'd0,
    MODE_ABS    = 2'd1,
    MODE_BYPASS = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned K_TL   = 0;
  localparam int unsigned K_TC   = 1;
  localparam int unsigned K_TR   = 2;
  localparam int unsigned K_ML   = 3;
  localparam int unsigned K_MC   = 4;
  localparam int unsigned K_MR   = 5;
  localparam int unsigned K_BL   = 6;
  localparam int unsigned K_BC   = 7;
  localparam int unsigned K_BR   = 8;
  localparam int unsigned K_TAPS = 9;

  // Signed weight times zero-extended pixel needs 2*PIX_W+1 bits; nine of
  // them summed need four more.
  function automatic int unsigned acc_width(input int unsigned pix_w);
    return 2 * pix_w + 5;
  endfunction

endpackage

// File: rtl/conv3x3_row_unit.sv
// conv3x3_row_unit: one full output row of 3x3 convolution per enabled cycle.
//   clk, reset - clock, synchronous active-high reset (clears out_row)
//   en         - register a new output row at the end of this cycle
//   kernel     - nine signed weights, w0 in the LSBs
//   shift      - arithmetic right shift applied to each accumulator
//   mode       - CLAMP / ABS / BYPASS (reserved behaves as CLAMP)
//   row_top/row_mid/row_bot - window rows, IMG_W+2 pixels each
//   out_row    - registered output row, pixel c at [c*PIX_W +: PIX_W]
module conv3x3_row_unit
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned PIX_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [K_TAPS*PIX_W-1:0]      kernel,
  input  logic [3:0]                   shift,
  input  mode_e                        mode,
  input  logic [(IMG_W+2)*PIX_W-1:0]   row_top,
  input  logic [(IMG_W+2)*PIX_W-1:0]   row_mid,
  input  logic [(IMG_W+2)*PIX_W-1:0]   row_bot,
  output logic [IMG_W*PIX_W-1:0]       out_row
);

  localparam int unsigned ACC_W = acc_width(PIX_W);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((64'd1 << PIX_W) - 64'd1);

  logic signed [ACC_W-1:0] wgt [K_TAPS];
  logic [IMG_W*PIX_W-1:0]  res_row;

  always_comb begin
    for (int unsigned k = 0; k < K_TAPS; k++) begin
      wgt[k] = ACC_W'($signed(kernel[k*PIX_W +: PIX_W]));
    end
  end

  for (genvar c = 0; c < IMG_W; c++) begin : g_col
    logic [PIX_W-1:0]        tap [K_TAPS];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shd;
    logic signed [ACC_W-1:0] mag;
    logic [PIX_W-1:0]        res;

    assign tap[K_TL] = row_top[(c+0)*PIX_W +: PIX_W];
    assign tap[K_TC] = row_top[(c+1)*PIX_W +: PIX_W];
    assign tap[K_TR] = row_top[(c+2)*PIX_W +: PIX_W];
    assign tap[K_ML] = row_mid[(c+0)*PIX_W +: PIX_W];
    assign tap[K_MC] = row_mid[(c+1)*PIX_W +: PIX_W];
    assign tap[K_MR] = row_mid[(c+2)*PIX_W +: PIX_W];
    assign tap[K_BL] = row_bot[(c+0)*PIX_W +: PIX_W];
    assign tap[K_BC] = row_bot[(c+1)*PIX_W +: PIX_W];
    assign tap[K_BR] = row_bot[(c+2)*PIX_W +: PIX_W];

    always_comb begin
      acc = '0;
      for (int unsigned k = 0; k < K_TAPS; k++) begin
        acc = acc + wgt[k] * signed'(ACC_W'(tap[k]));
      end
      shd = acc >>> shift;
      mag = shd;
      res = '0;
      case (mode)
        MODE_BYPASS: res = tap[K_MC];
        MODE_ABS: begin
          // Magnitude is taken after the shift, so negative results round
          // toward -inf before being folded positive.
          mag = shd[ACC_W-1] ? -shd : shd;
          res = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
        end
        default: begin
          if (shd[ACC_W-1])        res = '0;
          else if (shd > PIX_MAX)  res = '1;
          else                     res = shd[PIX_W-1:0];
        end
      endcase
    end

    assign res_row[c*PIX_W +: PIX_W] = res;
  end

  always_ff @(posedge clk) begin
    if (reset)   out_row <= '0;
    else if (en) out_row <= res_row;
  end

endmodule

// File: rtl/conv3x3_row_engine.sv
// conv3x3_row_engine: reads zero-padded image rows from an input memory,
// keeps a 3-row sliding window and writes one convolved row per cycle.
//   clk, reset       - clock, synchronous active-high reset (aborts a run)
//   start            - run request, sampled only in IDLE
//   kernel/shift/mode - configuration, latched when start is accepted
//   busy, done       - run in progress / one-cycle end-of-run pulse
//   rd_en, rd_addr, rd_data - input row memory, data valid 1 cycle after rd_en
//   wr_en, wr_addr, wr_data - output row memory
module conv3x3_row_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [9*PIX_W-1:0]          kernel,
  input  logic [3:0]                  shift,
  input  logic [1:0]                  mode,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [(IMG_W+2)*PIX_W-1:0]  rd_data,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [IMG_W*PIX_W-1:0]      wr_data
);

  localparam int unsigned ROW_IN_W = (IMG_W + 2) * PIX_W;
  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(IMG_H + 1);
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(IMG_H - 1);

  if ((64'd1 << ADDR_W) < 64'(IMG_H + 2)) begin : g_addr_check
    $error("ADDR_W cannot address IMG_H+2 input rows");
  end

  state_e state, state_nxt;

  logic [ADDR_W-1:0]        rd_row;
  logic [ADDR_W-1:0]        out_row_cnt;
  logic                     cap_vld;
  logic [ROW_IN_W-1:0]      win0, win1, win2;
  logic [2:0]               tag;
  logic [K_TAPS*PIX_W-1:0]  kernel_q;
  logic [3:0]               shift_q;
  mode_e                    mode_q;
  logic                     accept;
  logic                     compute_en;

  assign accept     = (state == IDLE) && start;
  // tag[2] follows win2, tag[0] follows win0; all set means three real rows.
  assign compute_en = &tag;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = rd_row;
        if (rd_row == LAST_RD) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_en && (wr_addr == LAST_WR)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_row      <= '0;
      out_row_cnt <= '0;
      cap_vld     <= 1'b0;
      win0        <= '0;
      win1        <= '0;
      win2        <= '0;
      tag         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      kernel_q    <= '0;
      shift_q     <= '0;
      mode_q      <= MODE_CLAMP;
    end else begin
      cap_vld <= rd_en;
      win0    <= win1;
      win1    <= win2;
      win2    <= cap_vld ? rd_data : '0;
      tag     <= {cap_vld, tag[2:1]};
      wr_en   <= compute_en;
      if (compute_en) begin
        wr_addr     <= out_row_cnt;
        out_row_cnt <= out_row_cnt + 1'b1;
      end
      if (accept) begin
        kernel_q    <= kernel;
        shift_q     <= shift;
        mode_q      <= mode_e'(mode);
        rd_row      <= '0;
        out_row_cnt <= '0;
      end else if (state == READ) begin
        rd_row <= rd_row + 1'b1;
      end
    end
  end

  conv3x3_row_unit #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_row_unit (
    .clk     (clk),
    .reset   (reset),
    .en      (compute_en),
    .kernel  (kernel_q),
    .shift   (shift_q),
    .mode    (mode_q),
    .row_top (win0),
    .row_mid (win1),
    .row_bot (win2),
    .out_row (wr_data)
  );

endmodule

// File: tb/tb_conv3x3_row_engine.sv
// Self-checking bench for conv3x3_row_engine on a 4x4 image.
module tb_conv3x3_row_engine;

  localparam int unsigned IMG_W     = 4;
  localparam int unsigned IMG_H     = 4;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned ROW_IN_W  = (IMG_W + 2) * PIX_W;
  localparam int unsigned ROW_OUT_W = IMG_W * PIX_W;

  typedef logic [IMG_H*IMG_W-1:0][7:0] img_out_t;
  typedef logic [8:0][7:0]             kern_t;

  typedef struct packed {
    logic [1:0] img_kind;
    kern_t      w;
    logic [3:0] shift;
    logic [1:0] mode;
    img_out_t   exp;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [9*PIX_W-1:0]    kernel;
  logic [3:0]            shift;
  logic [1:0]            mode;
  logic                  busy, done, rd_en, wr_en;
  logic [ADDR_W-1:0]     rd_addr, wr_addr;
  logic [ROW_IN_W-1:0]   rd_data;
  logic [ROW_OUT_W-1:0]  wr_data;

  int img [0:IMG_H+1][0:IMG_W+1];
  int errors = 0;
  int checks = 0;
  vec_t vecs [7];

  always #5 clk = ~clk;

  conv3x3_row_engine #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .kernel  (kernel),
    .shift   (shift),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  function automatic logic [ROW_IN_W-1:0] pack_row(input int r);
    logic [ROW_IN_W-1:0] v;
    v = '0;
    for (int c = 0; c < IMG_W + 2; c++) v[c*PIX_W +: PIX_W] = PIX_W'(img[r][c]);
    return v;
  endfunction

  // Input memory: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en && (int'(rd_addr) < IMG_H + 2)) rd_data <= pack_row(int'(rd_addr));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // kind 0: ramp 1..16, 1: all 10, 2: all 255, 3: random. Pads are zero.
  task automatic set_image(input int kind);
    for (int r = 0; r < IMG_H + 2; r++)
      for (int c = 0; c < IMG_W + 2; c++) img[r][c] = 0;
    for (int r = 1; r <= IMG_H; r++)
      for (int c = 1; c <= IMG_W; c++)
        case (kind)
          0:       img[r][c] = (r - 1) * IMG_W + c;
          1:       img[r][c] = 10;
          2:       img[r][c] = 255;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  function automatic img_out_t exp_ramp();
    img_out_t o;
    for (int i = 0; i < IMG_H * IMG_W; i++) o[i] = 8'(i + 1);
    return o;
  endfunction

  function automatic img_out_t exp_ring(input int corner, input int edge_v, input int inner);
    img_out_t o;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        bit br, bc;
        br = (r == 0) || (r == IMG_H - 1);
        bc = (c == 0) || (c == IMG_W - 1);
        o[r*IMG_W+c] = (br && bc) ? 8'(corner) : (br || bc) ? 8'(edge_v) : 8'(inner);
      end
    return o;
  endfunction

  function automatic kern_t kfill(input int v);
    kern_t k;
    for (int i = 0; i < 9; i++) k[i] = 8'(v);
    return k;
  endfunction

  function automatic kern_t kcenter(input int v);
    kern_t k;
    k    = '0;
    k[4] = 8'(v);
    return k;
  endfunction

  // Reference: direct 2-D convolution over the padded image.
  function automatic img_out_t model(input kern_t w, input int sh, input int md);
    img_out_t o;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        int acc;
        int v;
        acc = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            acc += int'($signed(w[dr*3+dc])) * img[r+dr][c+dc];
        if (md == 2) v = img[r+1][c+1];
        else begin
          v = acc >>> sh;
          if (md == 1 && v < 0) v = -v;
          if (v < 0)   v = 0;
          if (v > 255) v = 255;
        end
        o[r*IMG_W+c] = 8'(v);
      end
    return o;
  endfunction

  // One run, checked cycle by cycle. Cycle T is the one in which start is
  // first sampled; n counts cycles after it. Config pins are scrambled
  // during the run. start stays high for cycles T..T+hold-1 and again at
  // T+pulse_at.
  task automatic run(input string name, input kern_t w, input logic [3:0] sh,
                     input logic [1:0] md, input img_out_t exp,
                     input int hold, input int pulse_at);
    logic [ROW_OUT_W-1:0] er;
    @(negedge clk);
    start  = 1'b1;
    kernel = w;
    shift  = sh;
    mode   = md;
    for (int n = 1; n <= IMG_H + 9; n++) begin
      bit rde, wre;
      @(negedge clk);
      start  = (n < hold) || (n == pulse_at);
      kernel = 72'({$urandom(), $urandom(), $urandom()});
      shift  = 4'($urandom());
      mode   = 2'($urandom());
      rde = (n <= IMG_H + 2);
      wre = (n >= 6) && (n <= IMG_H + 5);
      chk({name, " busy"},  64'(busy),  64'(n <= IMG_H + 5));
      chk({name, " done"},  64'(done),  64'(n == IMG_H + 6));
      chk({name, " rd_en"}, 64'(rd_en), 64'(rde));
      chk({name, " wr_en"}, 64'(wr_en), 64'(wre));
      if (rde) chk({name, " rd_addr"}, 64'(rd_addr), 64'(n - 1));
      if (wre) begin
        er = exp[(n-6)*IMG_W +: IMG_W];
        chk({name, " wr_addr"}, 64'(wr_addr), 64'(n - 6));
        chk({name, " wr_data"}, 64'(wr_data), 64'(er));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    kern_t    w;
    img_out_t e;
    logic [3:0] sh;
    logic [1:0] md;

    vecs[0] = '{img_kind: 2'd0, w: kcenter(1),  shift: 4'd0, mode: 2'd0, exp: exp_ramp()};
    vecs[1] = '{img_kind: 2'd1, w: kfill(-1),   shift: 4'd0, mode: 2'd0, exp: exp_ring(0, 0, 0)};
    vecs[2] = '{img_kind: 2'd1, w: kfill(-1),   shift: 4'd0, mode: 2'd1, exp: exp_ring(40, 60, 90)};
    vecs[3] = '{img_kind: 2'd2, w: kfill(1),    shift: 4'd3, mode: 2'd0, exp: exp_ring(127, 191, 255)};
    vecs[4] = '{img_kind: 2'd0, w: kfill(-77),  shift: 4'd7, mode: 2'd2, exp: exp_ramp()};
    vecs[5] = '{img_kind: 2'd1, w: kfill(1),    shift: 4'd0, mode: 2'd3, exp: exp_ring(40, 60, 90)};
    vecs[6] = '{img_kind: 2'd0, w: kcenter(-1), shift: 4'd0, mode: 2'd1, exp: exp_ramp()};

    reset  = 1'b1;
    start  = 1'b0;
    kernel = '0;
    shift  = '0;
    mode   = '0;
    set_image(0);
    repeat (3) @(negedge clk);
    chk("reset busy",    64'(busy),    64'd0);
    chk("reset done",    64'(done),    64'd0);
    chk("reset rd_en",   64'(rd_en),   64'd0);
    chk("reset wr_en",   64'(wr_en),   64'd0);
    chk("reset rd_addr", 64'(rd_addr), 64'd0);
    chk("reset wr_addr", 64'(wr_addr), 64'd0);
    chk("reset wr_data", 64'(wr_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      set_image(int'(vecs[i].img_kind));
      run($sformatf("vec%0d", i), vecs[i].w, vecs[i].shift, vecs[i].mode, vecs[i].exp, 1, 0);
    end

    // start held three cycles plus a stray pulse mid-run; one run expected.
    set_image(3);
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom());
    e = model(w, 2, 0);
    run("held_start", w, 4'd2, 2'd0, e, 3, 4);

    // start pulse during DONE must not begin another run.
    set_image(3);
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom());
    e = model(w, 1, 1);
    run("done_start", w, 4'd1, 2'd1, e, 1, IMG_H + 6);

    for (int t = 0; t < 12; t++) begin
      set_image(3);
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom());
      sh = 4'($urandom_range(0, 8));
      md = 2'($urandom_range(0, 3));
      e  = model(w, int'(sh), int'(md));
      run($sformatf("rand%0d", t), w, sh, md, e, 1, 0);
    end

    // Reset in the middle of a run aborts it cleanly.
    set_image(2);
    @(negedge clk);
    start  = 1'b1;
    kernel = kfill(1);
    shift  = 4'd0;
    mode   = 2'd0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (n == 4);
      if (n < 4) chk("abort pre busy", 64'(busy), 64'd1);
      if (n >= 5) begin
        chk("abort busy",  64'(busy),  64'd0);
        chk("abort rd_en", 64'(rd_en), 64'd0);
        chk("abort wr_en", 64'(wr_en), 64'd0);
        chk("abort done",  64'(done),  64'd0);
      end
    end
    reset = 1'b0;
    set_image(0);
    run("post_abort", kcenter(1), 4'd0, 2'd0, exp_ramp(), 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv3x3_row_engine.md
Name: conv3x3_row_engine

Overview:
- Parametrised successor to the fixed 128-wide convolution datapath and its separate input/output sequencers.
- A single block now sequences reads of zero-padded image rows from an input BRAM, keeps a 3-row sliding window, and computes one full output row of 3x3 convolution per cycle.
- Each output row is written to an output BRAM.
- Adds a start/busy/done handshake, latched configuration, post-shift, and selectable output modes.

Parameters:
- IMG_W, 128, output pixels per row; input rows are IMG_W+2 pixels, with zero pads at columns 0 and IMG_W+1.
- IMG_H, 128, output rows; input memory holds IMG_H+2 rows, with zero pad rows at 0 and IMG_H+1.
- PIX_W, 8, pixel and weight width; pixels are unsigned, weights are signed.
- ADDR_W, 8, memory address width; must satisfy 2^ADDR_W >= IMG_H+2 (elaboration-time check).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- kernel  in  9*PIX_W  weights; w0 in the LSBs, row-major with w0 at top-left; each weight signed.
- shift  in  4  arithmetic right shift applied to the accumulator.
- mode  in  2  0=CLAMP, 1=ABS, 2=BYPASS, 3=reserved (behaves as CLAMP).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a run.
- rd_en  out  1  input memory read enable.
- rd_addr  out  ADDR_W  input row address.
- rd_data  in  (IMG_W+2)*PIX_W  input row; valid exactly 1 cycle after rd_en.
- wr_en  out  1  output memory write enable.
- wr_addr  out  ADDR_W  output row address.
- wr_data  out  IMG_W*PIX_W  output row; pixel c occupies bits [c*PIX_W +: PIX_W].

Behaviour:
- Reset: all outputs 0, FSM to IDLE, window registers and counters cleared. Reset mid-run aborts immediately: no further rd_en/wr_en and no done pulse.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start=1, latch kernel, shift and mode, then go to READ.
  - READ: rd_en=1 with rd_addr = 0..IMG_H+1, one per cycle; after address IMG_H+1, go to DRAIN.
  - DRAIN: wait for the last write, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, then return to IDLE.
- start while busy is ignored. A start held high for several cycles yields exactly one run; a new run needs start high again in IDLE.
- Input pins kernel, shift and mode may change during a run with no effect.
- Timing, with T = the cycle start is sampled in IDLE:
  - rd_addr k is issued at T+1+k.
  - rd_data for row k is captured at the end of T+2+k.
  - Window: win0<=win1, win1<=win2, win2<=rd_data. A row-valid tag shifts alongside the window.
  - The window holds rows j..j+2 during T+5+j; the result is registered at the end of that cycle.
  - wr_en=1, wr_addr=j during T+6+j, for j = 0..IMG_H-1.
  - done=1 at T+IMG_H+6; busy is high T+1..T+IMG_H+5.
  - Next start is accepted from T+IMG_H+7.
- Arithmetic, per output column c using window columns c..c+2:
  - acc = sum of w[i] * zero-extended pixel, computed signed with ACC_W = 2*PIX_W+5 bits (no overflow is possible).
  - Then acc >>> shift (arithmetic).
  - CLAMP: values <0 give 0; values >2^PIX_W-1 give 2^PIX_W-1.
  - ABS: magnitude, then clamp high.
  - BYPASS: output the window center pixel (win1, column c+1); kernel and shift are ignored.
- Pads are supplied by memory contents; the block does no edge handling of its own.

Decomposition:
- Package conv_pkg holds:
  - mode encodings (MODE_CLAMP, MODE_ABS, MODE_BYPASS);
  - the FSM state enum;
  - the ACC_W derivation function;
  - the kernel weight index constants.
- Sub-module conv3x3_row_unit: IMG_W generate-replicated 3x3 MAC, shift and mode logic with a registered output row, fed by the three window rows. The FSM, counters and window registers stay in the top module.

Test Plan:
- IMG_W=4, IMG_H=4, input rows 1..4 = ramp 1..16, identity kernel (w4=1), shift 0, CLAMP -> wr_data rows equal the input interior; wr at T+6..T+9 with addresses 0..3; done at T+10; busy T+1..T+9.
- All weights -1, image all 10, CLAMP -> every pixel 0. Same setup in ABS -> corners 40, edges 60, interior 90.
- All weights 1, shift 3, image all 255, CLAMP -> interior 2295>>3 = 286, clamped to 255; corners 1020>>3 = 127; edges 1530>>3 = 191.
- BYPASS with an arbitrary kernel and shift=7 -> output equals the input interior exactly.
- start held high 3 cycles, plus a second start pulse at T+4 -> exactly 4 writes and one done; change kernel mid-run -> results use the latched kernel.
- reset asserted at T+4 -> from T+5 busy, rd_en, wr_en and done are all 0, with no done pulse. A fresh start afterwards gives a full correct run, with no leftover window data in row 0.
